// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the serial BCD adder/subtractor: FSM state encoding,
// BCD constants and the per-digit nine's-complement helper.
package bcd_serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add of two digits plus carry, then +6
// correction whenever the binary sum leaves the decimal range.
module bcd_digit_add
  import bcd_serial_addsub_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co
);

  logic [4:0] w_t;
  logic [3:0] w_adj;

  assign w_t   = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  // Only the low nibble of t+6 is kept, so a 4-bit add is sufficient.
  assign w_adj = w_t[3:0] + BCD_ADJ;
  assign co    = (w_t > {1'b0, BCD_MAX});
  assign d     = co ? w_adj : w_t[3:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD
// first, with ten's-complement subtraction and invalid-digit flagging.
module bcd_serial_addsub
  import bcd_serial_addsub_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int W    = 4 * NDIG,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         invalid
);

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_res;
  logic           r_carry;
  logic           r_sub;
  logic           r_inv_pend;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_sum;
  logic           r_cout;
  logic           r_invalid;

  logic [NDIG-1:0] w_bad;
  logic [W-1:0]    w_b_in;
  logic [3:0]      w_d;
  logic            w_co;
  logic            w_last;
  logic [W-1:0]    w_res_next;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign w_bad[gi] = (a[4*gi +: 4] > BCD_MAX) | (b[4*gi +: 4] > BCD_MAX);
      assign w_b_in[4*gi +: 4] = op_sub ? nines_comp(b[4*gi +: 4]) : b[4*gi +: 4];
    end
  endgenerate

  bcd_digit_add u_digit (
    .x  (r_a[3:0]),
    .y  (r_b[3:0]),
    .ci (r_carry),
    .d  (w_d),
    .co (w_co)
  );

  assign w_last     = (r_cnt == CW'(NDIG - 1));
  // New digit enters at the MS end; after NDIG shifts digit 0 sits in [3:0].
  assign w_res_next = W'({w_d, r_res} >> 4);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_sub      <= 1'b0;
      r_inv_pend <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start) begin
        r_a        <= a;
        r_b        <= w_b_in;
        r_sub      <= op_sub;
        r_inv_pend <= |w_bad;
        // Subtraction is a + 9's(b) + 1, so a borrow-in removes that +1.
        r_carry    <= cin ^ op_sub;
        r_cnt      <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> 4;
        r_b     <= r_b >> 4;
        r_res   <= w_res_next;
        r_carry <= w_co;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum     <= r_inv_pend ? '0 : w_res_next;
          r_cout    <= r_inv_pend ? 1'b0 : (w_co ^ r_sub);
          r_invalid <= r_inv_pend;
        end
      end
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign sum     = r_sum;
  assign cout    = r_cout;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (NDIG=4): directed cases plus
// random operands checked against an integer-arithmetic decimal model.
module tb_bcd_serial_addsub;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int n_cmp = 0;
  int n_err = 0;
  int n_op  = 0;
  logic [W-1:0] prev_sum;

  bcd_serial_addsub #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_sub  (op_sub),
    .cin     (cin),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Decimal reference: convert to integers, do the arithmetic, wrap modulo 10^NDIG.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       input logic mc, output logic [W-1:0] s, output logic co,
                       output logic inv);
    int va, vb, r, modv;
    logic [W-1:0] tmp;
    va = 0; vb = 0; inv = 1'b0; modv = 1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) inv = 1'b1;
      va = va * 10 + int'(ma[4*i +: 4]);
      vb = vb * 10 + int'(mb[4*i +: 4]);
      modv = modv * 10;
    end
    if (inv) begin
      s = '0; co = 1'b0;
    end else begin
      if (ms) begin
        r  = va - vb - int'(mc);
        co = (r < 0);
        if (r < 0) r = r + modv;
      end else begin
        r  = va + vb + int'(mc);
        co = (r >= modv);
        if (r >= modv) r = r - modv;
      end
      tmp = '0;
      for (int i = 0; i < NDIG; i++) begin
        tmp[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
      s = tmp;
    end
  endtask

  // Wait (bounded) for done; checks that outputs hold while the op is in flight.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      chk("hold_sum", sum, prev_sum);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic ts, input logic tc);
    logic [W-1:0] es;
    logic ec, ei;
    int cyc;
    model(ta, tbv, ts, tc, es, ec, ei);
    start = 1'b1; a = ta; b = tbv; op_sub = ts; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    op_sub = 1'($urandom); cin = 1'($urandom);
    chk("busy_after_start", busy, 1);
    wait_done(cyc);
    chk("latency", cyc, NDIG);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("invalid", invalid, ei);
    prev_sum = es;
    n_op++;
    $display("op %0d: a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d invalid=%0d (model %h/%0d/%0d)",
             n_op, ta, tbv, ts, tc, sum, cout, invalid, es, ec, ei);
    @(posedge clk); #1;
    chk("ready_after_done", ready, 1);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    int cyc;
    logic saw_done;
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    prev_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_invalid", invalid, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed adds and subtracts
    do_op(16'h0025, 16'h0052, 1'b0, 1'b0);
    do_op(16'h0099, 16'h0088, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op(16'h0099, 16'h0000, 1'b0, 1'b1);
    do_op(16'h0093, 16'h0012, 1'b1, 1'b0);
    do_op(16'h0003, 16'h0005, 1'b1, 1'b0);
    do_op(16'h0010, 16'h0000, 1'b1, 1'b1);
    // Invalid digit, then a valid op must clear the flag
    do_op(16'h00A1, 16'h0001, 1'b0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);

    // Handshake: start held through RUN and DONE is ignored
    start = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    a = 16'h4444; b = 16'h4444;
    wait_done(cyc);
    chk("hs_latency", cyc, NDIG);
    chk("hs_sum", sum, 16'h3333);
    $display("handshake op: sum=%h after %0d cycles", sum, cyc);
    prev_sum = 16'h3333;
    @(posedge clk); #1;
    chk("hs_ready_idle", ready, 1);
    @(posedge clk); #1;
    chk("hs_accept_first_idle", busy, 1);
    start = 1'b0;
    wait_done(cyc);
    chk("hs2_sum", sum, 16'h8888);
    $display("handshake follow-up op: sum=%h", sum);
    prev_sum = 16'h8888;
    @(posedge clk); #1;

    // Reset in the middle of RUN
    start = 1'b1; a = 16'h5555; b = 16'h4444; op_sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    saw_done = 1'b0;
    for (int i = 0; i < NDIG + 2; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", saw_done, 0);
    $display("mid-run reset: sum=%h cout=%0d ready=%0d", sum, cout, ready);
    prev_sum = '0;
    do_op(16'h5555, 16'h4444, 1'b0, 1'b0);

    // Random operations against the decimal model
    for (int k = 0; k < 40; k++) begin
      do_op(rand_bcd(), rand_bcd(), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
